clk_div_monitor: RTL and testbench

- Receive-side checker for a divided clock: samples a slow clock (clk_mon) in the clk_in domain and emits single-cycle rise/fall strobes.
- Measures the clk_in-cycle length of every half period and declares lock once a run of intervals lands within tolerance of the expected value.
- Flags loss of clock via watchdog and counts in-lock timing errors; used to qualify divided clocks feeding the hashing cores.

---
 rtl/clk_div_monitor.sv | 138 +++++++++++++
 tb/tb_clk_div_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock checker: synchronises clk_mon, measures each half period in clk_in
// cycles, and tracks lock, loss of clock and in-lock timing errors.
//
// state   | meaning
// --------+-----------------------------------------------------------
// SEARCH  | after reset, waiting for the first (partial) interval
// ACQUIRE | counting consecutive in-tolerance intervals toward lock
// LOCKED  | LOCK_COUNT good intervals seen; bad interval counts an error
// LOST    | no edge for TIMEOUT cycles; next edge restarts acquisition
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_HALF   = 1,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int ERR_W      = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clk_mon,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             clk_lost,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, LOST} state_t;

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam int LO = EXP_HALF - TOL;
    localparam int HI = EXP_HALF + TOL;

    logic              s1, s2, s3;
    logic              mon_edge;
    logic [CNT_W-1:0]  half_cnt;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W:0]    cnt_plus;
    logic              good;
    logic              timeout_hit;
    logic              err_inc;
    state_t            state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_cnt_nxt;

    assign mon_edge = s2 ^ s3;
    assign meas     = (half_cnt == CNT_MAX) ? CNT_MAX : half_cnt + 1'b1;

    // one extra bit so the timeout compare cannot wrap at the counter ceiling
    assign cnt_plus    = {1'b0, half_cnt} + 1'b1;
    assign timeout_hit = !mon_edge && (cnt_plus >= (CNT_W+1)'(TIMEOUT));

    // signed integer compare keeps a negative lower bound (TOL > EXP_HALF) meaningful
    assign good = (int'(meas) >= LO) && (int'(meas) <= HI);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            half_cnt    <= '0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            err_count   <= '0;
        end else begin
            s1         <= clk_mon;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3;
            fall_pulse <= ~s2 & s3;
            meas_valid <= mon_edge;
            if (mon_edge) begin
                half_period <= meas;
                half_cnt    <= '0;
            end else if (half_cnt != CNT_MAX) begin
                half_cnt <= half_cnt + 1'b1;
            end
            if (err_inc && (err_count != ERR_MAX)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        err_inc      = 1'b0;
        if (timeout_hit) begin
            state_nxt    = LOST;
            good_cnt_nxt = '0;
        end else if (mon_edge) begin
            case (state)
                // interval ending here started at an unknown point, so it is not judged
                SEARCH, LOST: begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
                ACQUIRE: begin
                    if (!good) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt + 1'b1 == GOOD_W'(LOCK_COUNT)) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        state_nxt    = ACQUIRE;
                        good_cnt_nxt = '0;
                        err_inc      = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    assign locked   = (state == LOCKED);
    assign clk_lost = (state == LOST);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: four parameterisations, random intervals checked against
// an interval-level lock model, a constant vector table, and hand-written corner cases.
module tb_clk_div_monitor;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [3:0] mon, rise, fall, mv, lk, ls;
    logic [7:0] hp_a, hp_b, hp_c, ec_a, ec_b, ec_c, ec_d;
    logic [3:0] hp_d;

    always #5 clk_in = ~clk_in;

    clk_div_monitor #(.CNT_W(8), .EXP_HALF(3), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(16), .ERR_W(8)) u_a (
        .clk_in(clk_in), .reset(reset), .clk_mon(mon[0]), .rise_pulse(rise[0]), .fall_pulse(fall[0]),
        .half_period(hp_a), .meas_valid(mv[0]), .locked(lk[0]), .clk_lost(ls[0]), .err_count(ec_a));

    clk_div_monitor u_b (
        .clk_in(clk_in), .reset(reset), .clk_mon(mon[1]), .rise_pulse(rise[1]), .fall_pulse(fall[1]),
        .half_period(hp_b), .meas_valid(mv[1]), .locked(lk[1]), .clk_lost(ls[1]), .err_count(ec_b));

    clk_div_monitor #(.CNT_W(8), .EXP_HALF(3), .TOL(1), .LOCK_COUNT(4), .TIMEOUT(64), .ERR_W(8)) u_c (
        .clk_in(clk_in), .reset(reset), .clk_mon(mon[2]), .rise_pulse(rise[2]), .fall_pulse(fall[2]),
        .half_period(hp_c), .meas_valid(mv[2]), .locked(lk[2]), .clk_lost(ls[2]), .err_count(ec_c));

    clk_div_monitor #(.CNT_W(4), .EXP_HALF(3), .TOL(0), .LOCK_COUNT(4), .TIMEOUT(12), .ERR_W(8)) u_d (
        .clk_in(clk_in), .reset(reset), .clk_mon(mon[3]), .rise_pulse(rise[3]), .fall_pulse(fall[3]),
        .half_period(hp_d), .meas_valid(mv[3]), .locked(lk[3]), .clk_lost(ls[3]), .err_count(ec_d));

    typedef struct {int c; bit r; int d;} exp_t;
    typedef struct {int c; bit r; bit f; bit mv; int hp; bit lk; bit ls; int ec;} cap_t;
    typedef struct {int d; int hp; bit lk; int ec;} vec_t;

    exp_t exp_q[$];
    cap_t cap_q[$];
    cap_t cap_tmp, cap_cur;
    exp_t exp_cur;
    vec_t tbl[17];

    int cyc = 0;
    int act = 0;
    int last_t = -1;
    int total = 0;
    int passed = 0;
    int rnd_d;
    int r_cyc;
    int e_cyc;
    int m_run, m_err;
    bit m_lk, m_first;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int hp_of(input int i);
        case (i)
            0: return int'(hp_a);
            1: return int'(hp_b);
            2: return int'(hp_c);
            default: return int'(hp_d);
        endcase
    endfunction

    function automatic int ec_of(input int i);
        case (i)
            0: return int'(ec_a);
            1: return int'(ec_b);
            2: return int'(ec_c);
            default: return int'(ec_d);
        endcase
    endfunction

    // every strobe or measurement on the active instance is logged with its cycle
    always @(negedge clk_in) begin
        if (rise[act] | fall[act] | mv[act]) begin
            cap_tmp.c  = cyc;
            cap_tmp.r  = rise[act];
            cap_tmp.f  = fall[act];
            cap_tmp.mv = mv[act];
            cap_tmp.hp = hp_of(act);
            cap_tmp.lk = lk[act];
            cap_tmp.ls = ls[act];
            cap_tmp.ec = ec_of(act);
            cap_q.push_back(cap_tmp);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    task automatic model_reset();
        m_run = 0; m_err = 0; m_lk = 0; m_first = 1;
    endtask

    task automatic model_lost();
        m_run = 0; m_lk = 0; m_first = 1;
    endtask

    // lock means the last lc judged intervals were all within tolerance
    task automatic model_edge(input int d, input int exph, input int tol, input int lc);
        if (m_first) begin
            m_first = 0;
            m_run   = 0;
        end else if (d >= exph - tol && d <= exph + tol) begin
            m_run++;
            if (m_run >= lc) m_lk = 1;
        end else begin
            if (m_lk && m_err < 255) m_err++;
            m_lk  = 0;
            m_run = 0;
        end
    endtask

    task automatic toggle(input int sel);
        exp_t e;
        mon[sel] = ~mon[sel];
        e.c = cyc + 3;
        e.r = mon[sel];
        e.d = (last_t < 0) ? -1 : cyc - last_t;
        last_t = cyc;
        exp_q.push_back(e);
    endtask

    task automatic gap(input int sel, input int d);
        repeat (d) @(negedge clk_in);
        toggle(sel);
    endtask

    task automatic do_reset(input int sel);
        mon   = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        act   = sel;
        exp_q.delete();
        cap_q.delete();
        last_t = -1;
        model_reset();
    endtask

    task automatic check_edges(input int exph, input int tol, input int lc);
        repeat (5) @(negedge clk_in);
        chk("edge_count", cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0) begin
            exp_cur = exp_q.pop_front();
            cap_cur = cap_q.pop_front();
            model_edge(exp_cur.d, exph, tol, lc);
            chk("strobe_cycle", cap_cur.c, exp_cur.c);
            chk("rise_pulse", int'(cap_cur.r), int'(exp_cur.r));
            chk("fall_pulse", int'(cap_cur.f), int'(!exp_cur.r));
            chk("meas_valid", int'(cap_cur.mv), 1);
            if (exp_cur.d > 0) chk("half_period", cap_cur.hp, exp_cur.d);
            chk("locked", int'(cap_cur.lk), int'(m_lk));
            chk("clk_lost", int'(cap_cur.ls), 0);
            chk("err_count", cap_cur.ec, m_err);
        end
        exp_q.delete();
        cap_q.delete();
    endtask

    initial begin
        reset = 1'b0;
        mon   = '0;
        // TOL=1 table on u_c: {interval, half_period, locked, err_count}
        tbl[0]  = '{3, 3, 0, 0}; tbl[1]  = '{3, 3, 0, 0}; tbl[2]  = '{3, 3, 0, 0};
        tbl[3]  = '{3, 3, 1, 0}; tbl[4]  = '{2, 2, 1, 0}; tbl[5]  = '{4, 4, 1, 0};
        tbl[6]  = '{3, 3, 1, 0}; tbl[7]  = '{4, 4, 1, 0}; tbl[8]  = '{5, 5, 0, 1};
        tbl[9]  = '{3, 3, 0, 1}; tbl[10] = '{3, 3, 0, 1}; tbl[11] = '{3, 3, 0, 1};
        tbl[12] = '{1, 1, 0, 1}; tbl[13] = '{3, 3, 0, 1}; tbl[14] = '{3, 3, 0, 1};
        tbl[15] = '{3, 3, 0, 1}; tbl[16] = '{3, 3, 1, 1};

        // random intervals on u_a, mostly on target
        do_reset(0);
        gap(0, 2);
        for (int i = 0; i < 80; i++) begin
            rnd_d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 3;
            gap(0, rnd_d);
        end
        check_edges(3, 0, 4);

        // three lock/error cycles, then a one-cycle reset while locked
        do_reset(0);
        gap(0, 2);
        repeat (3) begin
            repeat (4) gap(0, 3);
            gap(0, 5);
        end
        repeat (4) gap(0, 3);
        check_edges(3, 0, 4);
        chk("pre_reset_locked", int'(lk[0]), 1);
        chk("pre_reset_err", int'(ec_a), 3);
        reset = 1'b0;
        @(negedge clk_in);
        chk("rst_rise", int'(rise[0]), 0);
        chk("rst_fall", int'(fall[0]), 0);
        chk("rst_meas_valid", int'(mv[0]), 0);
        chk("rst_half_period", int'(hp_a), 0);
        chk("rst_locked", int'(lk[0]), 0);
        chk("rst_clk_lost", int'(ls[0]), 0);
        chk("rst_err", int'(ec_a), 0);
        reset = 1'b1;
        exp_q.delete();
        cap_q.delete();
        last_t = -1;
        model_reset();
        gap(0, 2);
        repeat (4) gap(0, 3);
        check_edges(3, 0, 4);

        // loss of clock and recovery on u_a (TIMEOUT=16)
        do_reset(0);
        gap(0, 2);
        repeat (5) gap(0, 3);
        check_edges(3, 0, 4);
        e_cyc = last_t + 3;
        while (cyc < e_cyc + 15) @(negedge clk_in);
        chk("lost_before_timeout", int'(ls[0]), 0);
        chk("locked_before_timeout", int'(lk[0]), 1);
        @(negedge clk_in);
        chk("lost_at_timeout", int'(ls[0]), 1);
        chk("locked_at_timeout", int'(lk[0]), 0);
        model_lost();
        gap(0, 4);
        repeat (4) gap(0, 3);
        check_edges(3, 0, 4);

        // default parameters, divide-by-2 source on u_b
        do_reset(1);
        gap(1, 2);
        repeat (20) gap(1, 1);
        check_edges(1, 0, 4);

        // vector table on u_c
        do_reset(2);
        gap(2, 2);
        for (int i = 0; i < 17; i++) gap(2, tbl[i].d);
        repeat (5) @(negedge clk_in);
        chk("tbl_edge_count", cap_q.size(), 18);
        if (cap_q.size() > 0) begin
            void'(cap_q.pop_front());
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < 17 && cap_q.size() > 0 && exp_q.size() > 0; i++) begin
            cap_cur = cap_q.pop_front();
            exp_cur = exp_q.pop_front();
            chk("tbl_strobe_cycle", cap_cur.c, exp_cur.c);
            chk("tbl_half_period", cap_cur.hp, tbl[i].hp);
            chk("tbl_locked", int'(cap_cur.lk), int'(tbl[i].lk));
            chk("tbl_err_count", cap_cur.ec, tbl[i].ec);
        end

        // stuck clk_mon on u_d: exact timeout, then saturated first measurement
        do_reset(3);
        r_cyc = cyc;
        while (cyc < r_cyc + 11) @(negedge clk_in);
        chk("d_lost_before_timeout", int'(ls[3]), 0);
        @(negedge clk_in);
        chk("d_lost_at_timeout", int'(ls[3]), 1);
        while (cyc < r_cyc + 25) @(negedge clk_in);
        chk("d_idle_no_strobes", cap_q.size(), 0);
        toggle(3);
        repeat (5) @(negedge clk_in);
        chk("d_edge_count", cap_q.size(), 1);
        if (cap_q.size() > 0) begin
            cap_cur = cap_q.pop_front();
            chk("d_half_period_sat", cap_cur.hp, 15);
            chk("d_rise", int'(cap_cur.r), 1);
            chk("d_lost_cleared", int'(cap_cur.ls), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
